// File: rtl/core_pkg.sv
// Shared core definitions: default data width, register count and the
// register-address / data-word types used by the register file.
package core_pkg;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = $clog2(NREGS);

    typedef logic [AW-1:0]   reg_addr_t;
    typedef logic [XLEN-1:0] xword_t;
endpackage

// File: rtl/regfile_sb_fwd.sv
// One read port: zero/enable gating, writeback forwarding (load port has
// priority over ALU port) and the per-port stall term.
module regfile_sb_fwd #(
    parameter int XLEN   = 32,
    parameter int AW     = 5,
    parameter bit BYPASS = 1'b1
) (
    input  logic            reset,
    input  logic            renb,
    input  logic [AW-1:0]   rs,
    input  logic            wen_a,
    input  logic [AW-1:0]   wa_rd,
    input  logic [XLEN-1:0] wa_data,
    input  logic            wen_b,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic [XLEN-1:0] arr_data,
    input  logic            busy_bit,
    output logic [XLEN-1:0] rdata,
    output logic            hazard
);
    logic hit_a, hit_b, fwd, act;

    assign hit_a = wen_a && (wa_rd == rs);
    assign hit_b = wen_b && (wb_rd == rs);
    assign fwd   = BYPASS && (hit_a || hit_b);
    // reset gating keeps forwarded writeback data off the port during reset
    assign act   = renb && (rs != '0) && !reset;

    always_comb begin
        rdata = '0;
        if (act) begin
            if (BYPASS && hit_b)      rdata = wb_data;
            else if (BYPASS && hit_a) rdata = wa_data;
            else                      rdata = arr_data;
        end
    end

    assign hazard = act && busy_bit && !fwd;
endmodule

// File: rtl/regfile_sb.sv
// Dual-write-port register file with write-to-read bypass and a pending-write
// scoreboard that produces the decode stall.
module regfile_sb #(
    parameter int  XLEN   = core_pkg::XLEN,
    parameter int  NREGS  = core_pkg::NREGS,
    parameter bit  BYPASS = 1'b1,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [AW-1:0]    rs1,
    input  logic [AW-1:0]    rs2,
    input  logic             renb1,
    input  logic             renb2,
    output logic [XLEN-1:0]  rdata1,
    output logic [XLEN-1:0]  rdata2,
    input  logic             wen_a,
    input  logic [AW-1:0]    wa_rd,
    input  logic [XLEN-1:0]  wa_data,
    input  logic             wen_b,
    input  logic [AW-1:0]    wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    input  logic             issue_vld,
    input  logic [AW-1:0]    issue_rd,
    output logic             hazard,
    output logic [NREGS-1:0] busy
);
    logic [NREGS-1:0][XLEN-1:0] regs_q, regs_d;
    logic [NREGS-1:0]           busy_q, busy_d;

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wen_a) begin
            regs_d[wa_rd] = wa_data;
            busy_d[wa_rd] = 1'b0;
        end
        // load port applied second so it wins a same-rd collision
        if (wen_b) begin
            regs_d[wb_rd] = wb_data;
            busy_d[wb_rd] = 1'b0;
        end
        // a new producer outranks a retiring older one
        if (issue_vld) busy_d[issue_rd] = 1'b1;
        regs_d[0] = '0;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_q <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

    logic [1:0]           renb_v, haz_v;
    logic [1:0][AW-1:0]   rs_v;
    logic [1:0][XLEN-1:0] rd_v;

    assign renb_v = {renb2, renb1};
    assign rs_v   = {rs2, rs1};

    for (genvar p = 0; p < 2; p++) begin : g_rd
        regfile_sb_fwd #(.XLEN(XLEN), .AW(AW), .BYPASS(BYPASS)) u_fwd (
            .reset    (reset),
            .renb     (renb_v[p]),
            .rs       (rs_v[p]),
            .wen_a    (wen_a),
            .wa_rd    (wa_rd),
            .wa_data  (wa_data),
            .wen_b    (wen_b),
            .wb_rd    (wb_rd),
            .wb_data  (wb_data),
            .arr_data (regs_q[rs_v[p]]),
            .busy_bit (busy_q[rs_v[p]]),
            .rdata    (rd_v[p]),
            .hazard   (haz_v[p])
        );
    end

    assign rdata1 = rd_v[0];
    assign rdata2 = rd_v[1];
    assign hazard = |haz_v;
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised dual-write-port register file for the pipelined RISC-V core.
- Replaces the single-write regfile.
- Adds the following:
  - write-to-read bypass;
  - a per-register scoreboard of pending writes, set at issue and cleared at writeback;
  - a hazard output that drives decode-stage stall.
- Sits between decode (read/issue) and the two writeback paths: ALU (port A) and load unit (port B).

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers; power of two, 2..64
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads see array only
AW (localparam), $clog2(NREGS), register address width

Ports:
clk  in  1  clock
reset  in  1  async active-high reset
rs1  in  AW  read address 1
rs2  in  AW  read address 2
renb1  in  1  read enable 1
renb2  in  1  read enable 2
rdata1  out  XLEN  read data 1 (combinational)
rdata2  out  XLEN  read data 2 (combinational)
wen_a  in  1  ALU writeback enable
wa_rd  in  AW  ALU writeback address
wa_data  in  XLEN  ALU writeback data
wen_b  in  1  load writeback enable
wb_rd  in  AW  load writeback address
wb_data  in  XLEN  load writeback data
issue_vld  in  1  instruction with destination issued this cycle
issue_rd  in  AW  destination of issued instruction
hazard  out  1  decode must stall
busy  out  NREGS  scoreboard vector, bit i = write pending to xi

Behaviour:
- Clock and reset: reset reset, asynchronous, active-high; clock clk. All state is updated on the posedge of clk only.
- Reset:
  - All NREGS registers and all busy bits clear to 0 asynchronously.
  - rdata1, rdata2 and hazard are 0 while reset is high.
  - A reset in the middle of a pending writeback discards that write and its busy bit.
- x0:
  - Always reads 0.
  - Writes to x0 are ignored.
  - busy[0] is never set.
- Write:
  - At posedge, wen_a writes wa_data to r[wa_rd] and wen_b writes wb_data to r[wb_rd].
  - If both ports target the same nonzero rd in one cycle, port B (load) wins and port A's data is dropped.
- Read:
  - rdataN = 0 if renbN = 0 or rsN = 0.
  - Otherwise, with BYPASS = 1, rdataN takes the first match in this order: wb_data if wen_b and wb_rd == rsN; else wa_data if wen_a and wa_rd == rsN; else r[rsN].
  - With BYPASS = 0, rdataN = r[rsN]; the new value becomes visible the cycle after the write.
  - Read latency is 0 cycles (combinational).
- Scoreboard:
  - At posedge, busy[issue_rd] <= 1 when issue_vld and issue_rd != 0.
  - At posedge, busy[x] <= 0 when a write to x occurs on either port.
  - If a set and a clear hit the same register in the same cycle, the set wins (the newer producer is outstanding).
- Hazard:
  - hazard = OR over N in {1,2} of (renbN and rsN != 0 and busy[rsN] and not fwdN).
  - fwdN = BYPASS and (wen_a and wa_rd == rsN, or wen_b and wb_rd == rsN).
  - With BYPASS = 0, a busy source stalls until the cycle after its writeback.
- Issue while hazard: the block does not gate issue_vld; the pipeline must not assert issue_vld while hazard = 1.
- Write-after-write: a second issue to a busy rd keeps busy set. The first writeback then clears it. Correct WAW ordering is the pipeline's responsibility (in-order writeback).

Decomposition:
- Shared package (core_pkg): XLEN, NREGS, derived AW, and the reg_addr_t/xword_t typedefs.
- One natural sub-module: regfile_sb_fwd.
  - Per-read-port forwarding and hazard mux.
  - Instantiated twice, for rs1 and rs2.
- Array and scoreboard stay in the top module.

Test Plan:
- Reset clear: write x5 = 0xDEADBEEF, assert reset mid-cycle -> rdata1 for rs1 = 5 reads 0 and busy = 0 immediately, without waiting for a clock.
- x0 immunity: wen_a, wa_rd = 0, wa_data = 0x1234; issue_vld, issue_rd = 0 -> rdata1 for rs1 = 0 is 0; busy[0] = 0; hazard = 0.
- Bypass: BYPASS = 1, r[7] = 0x11; same cycle wen_a x7 = 0x22 and wen_b x7 = 0x33, rs1 = 7 -> rdata1 = 0x33; next cycle r[7] = 0x33. With BYPASS = 0 -> rdata1 = 0x11 that cycle, 0x33 next.
- Scoreboard stall: issue x3, next cycle rs2 = 3, renb2 = 1 -> hazard = 1 each cycle until wen_b x3 = 0xAB. BYPASS = 1: hazard drops in the writeback cycle with rdata2 = 0xAB. BYPASS = 0: hazard drops one cycle later.
- Set/clear collision: busy[9] = 1; same cycle wen_a x9 and issue_vld x9 -> busy[9] stays 1 and r[9] is updated.
- Disabled read: renb1 = 0, rs1 = 4, busy[4] = 1 -> rdata1 = 0 and hazard = 0.
